// File: rtl/spi_target_pkg.sv
// Shared types and constants for the SPI target: FSM states, frame width
// and the byte shifted out when the host has nothing queued.
package spi_target_pkg;

  localparam int         FRAME_BITS        = 8;
  localparam logic [7:0] IDLE_BYTE_DEFAULT = 8'hFF;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  function automatic logic [FRAME_BITS-1:0] select_out_byte(
    input logic                  full,
    input logic [FRAME_BITS-1:0] hold,
    input logic [FRAME_BITS-1:0] idle_byte
  );
    return full ? hold : idle_byte;
  endfunction

endpackage

// File: rtl/spi_target_sync_edge.sv
// Multi-stage synchronizer for one asynchronous SPI pin, with registered
// single-cycle rise/fall pulses derived from the synchronized level.
module spi_target_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain_reg;
  logic              prev_reg;
  logic              rise_reg;
  logic              fall_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chain_reg <= {STAGES{RST_VAL}};
      prev_reg  <= RST_VAL;
      rise_reg  <= 1'b0;
      fall_reg  <= 1'b0;
    end else begin
      chain_reg <= {chain_reg[STAGES-2:0], din};
      prev_reg  <= chain_reg[STAGES-1];
      // Pulses are registered so they line up with the FSM's one-cycle decision.
      rise_reg  <= chain_reg[STAGES-1] & ~prev_reg;
      fall_reg  <= ~chain_reg[STAGES-1] & prev_reg;
    end
  end

  assign dout = chain_reg[STAGES-1];
  assign rise = rise_reg;
  assign fall = fall_reg;

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target: oversamples sclk/cs_n/mosi on clk and exchanges 8-bit
// MSB-first frames with a byte-wide TX holding register and RX data register.
module spi_target
  import spi_target_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_BYTE   = IDLE_BYTE_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_we,
  output logic       tx_full,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       overrun,
  input  logic       ovr_clr,
  output logic       busy
);

  localparam int                 CNT_W    = $clog2(FRAME_BITS);
  localparam logic [CNT_W-1:0]   LAST_BIT = CNT_W'(FRAME_BITS - 1);

  logic sclk_rise, sclk_fall, unused_sclk_level;
  logic cs_level, cs_rise, cs_fall;
  logic mosi_level, unused_mosi_rise, unused_mosi_fall;

  state_t                state_reg, state_next;
  logic                  miso_reg, miso_next;
  logic                  miso_oe_reg, miso_oe_next;
  logic [FRAME_BITS-1:0] tx_shift_reg, tx_shift_next;
  logic [FRAME_BITS-1:0] rx_shift_reg, rx_shift_next;
  logic [CNT_W-1:0]      bit_cnt_reg, bit_cnt_next;
  logic [FRAME_BITS-1:0] tx_hold_reg, tx_hold_next;
  logic                  tx_full_reg, tx_full_next;
  logic [FRAME_BITS-1:0] rx_data_reg, rx_data_next;
  logic                  rx_valid_reg, rx_valid_next;
  logic                  overrun_reg, overrun_next;

  logic                  load_byte;
  logic                  byte_done;
  logic [FRAME_BITS-1:0] out_byte;
  logic [FRAME_BITS-1:0] rx_byte;

  spi_target_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .clk(clk), .rst_n(rst_n), .din(sclk),
    .dout(unused_sclk_level), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_target_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk(clk), .rst_n(rst_n), .din(cs_n),
    .dout(cs_level), .rise(cs_rise), .fall(cs_fall)
  );

  spi_target_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi_sync (
    .clk(clk), .rst_n(rst_n), .din(mosi),
    .dout(mosi_level), .rise(unused_mosi_rise), .fall(unused_mosi_fall)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      miso_reg     <= 1'b1;
      miso_oe_reg  <= 1'b0;
      tx_shift_reg <= '0;
      rx_shift_reg <= '0;
      bit_cnt_reg  <= '0;
      tx_hold_reg  <= '0;
      tx_full_reg  <= 1'b0;
      rx_data_reg  <= '0;
      rx_valid_reg <= 1'b0;
      overrun_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      miso_reg     <= miso_next;
      miso_oe_reg  <= miso_oe_next;
      tx_shift_reg <= tx_shift_next;
      rx_shift_reg <= rx_shift_next;
      bit_cnt_reg  <= bit_cnt_next;
      tx_hold_reg  <= tx_hold_next;
      tx_full_reg  <= tx_full_next;
      rx_data_reg  <= rx_data_next;
      rx_valid_reg <= rx_valid_next;
      overrun_reg  <= overrun_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    miso_next     = miso_reg;
    miso_oe_next  = ~cs_level;
    tx_shift_next = tx_shift_reg;
    rx_shift_next = rx_shift_reg;
    bit_cnt_next  = bit_cnt_reg;
    tx_hold_next  = tx_hold_reg;
    tx_full_next  = tx_full_reg;
    rx_data_next  = rx_data_reg;
    rx_valid_next = rx_valid_reg;
    overrun_next  = overrun_reg;
    load_byte     = 1'b0;
    byte_done     = 1'b0;
    out_byte      = select_out_byte(tx_full_reg, tx_hold_reg, IDLE_BYTE);
    rx_byte       = {rx_shift_reg[FRAME_BITS-2:0], mosi_level};

    case (state_reg)
      IDLE: begin
        if (cs_fall) begin
          state_next    = ACTIVE;
          load_byte     = 1'b1;
          miso_next     = out_byte[FRAME_BITS-1];
          tx_shift_next = out_byte << 1;
          bit_cnt_next  = '0;
        end
      end
      ACTIVE: begin
        // cs_n edges take priority over a coincident sclk edge.
        if (cs_rise) begin
          state_next   = IDLE;
          miso_next    = 1'b1;
          bit_cnt_next = '0;
        end else if (sclk_rise) begin
          rx_shift_next = rx_byte;
          bit_cnt_next  = bit_cnt_reg + 1'b1;
          if (bit_cnt_reg == LAST_BIT) begin
            byte_done     = 1'b1;
            load_byte     = 1'b1;
            rx_data_next  = rx_byte;
            tx_shift_next = out_byte;
          end
        end else if (sclk_fall) begin
          miso_next     = tx_shift_reg[FRAME_BITS-1];
          tx_shift_next = tx_shift_reg << 1;
        end
      end
    endcase

    if (load_byte && tx_full_reg) begin
      tx_full_next = 1'b0;
    end
    // Writes only land in an empty holding register, so a coincident load
    // with a full register still sees the old byte.
    if (tx_we && !tx_full_reg) begin
      tx_hold_next = tx_data;
      tx_full_next = 1'b1;
    end

    if (byte_done) begin
      rx_valid_next = 1'b1;
    end else if (rx_ack) begin
      rx_valid_next = 1'b0;
    end

    if (ovr_clr) begin
      overrun_next = 1'b0;
    end
    if (byte_done && rx_valid_reg && !rx_ack) begin
      overrun_next = 1'b1;
    end
  end

  assign miso     = miso_reg;
  assign miso_oe  = miso_oe_reg;
  assign tx_full  = tx_full_reg;
  assign rx_data  = rx_data_reg;
  assign rx_valid = rx_valid_reg;
  assign overrun  = overrun_reg;
  assign busy     = (state_reg == ACTIVE);

endmodule
